// File: rtl/note_mixer_pwm_if.sv
// Bundle between the note mixer and its surroundings: note waves and volume in, PWM audio and status out.
// Pure wiring, no latency of its own.
// No backpressure: every signal is level/pulse, sampled each clock by its receiver.
interface note_mixer_pwm_if #(
  parameter int N_NOTES = 12,
  parameter int VOL_W   = 7,
  parameter int PWM_W   = 11
) ();
  localparam int CNT_W = $clog2(N_NOTES + 1);

  logic [N_NOTES-1:0] ondas;
  logic [VOL_W-1:0]   volumen;
  logic               pwmOut;
  logic [CNT_W-1:0]   activeNotes;
  logic [PWM_W-1:0]   duty;
  logic               periodStart;

  // Driver side: supplies notes and volume, observes the audio output
  modport master (
    output ondas, volumen,
    input  pwmOut, activeNotes, duty, periodStart
  );

  // Mixer side
  modport slave (
    input  ondas, volumen,
    output pwmOut, activeNotes, duty, periodStart
  );
endinterface

// File: rtl/note_mixer_pwm.sv
// Mixes the per-note square waves into one slew-limited PWM audio pin (amplitude = notes x volume).
// Latency: note change -> activeNotes/target at 3rd edge; duty follows at the next period boundary.
// No backpressure: free-running PWM, inputs sampled every clock, duty only changes between periods.
module note_mixer_pwm #(
  parameter int N_NOTES   = 12,
  parameter int VOL_W     = 7,
  parameter int PWM_W     = 11,
  parameter int SLEW_STEP = 256
) (
  input  logic clockIn,
  input  logic reset,
  note_mixer_pwm_if.slave bus
);
  localparam int CNT_W  = $clog2(N_NOTES + 1);
  localparam int PROD_W = CNT_W + VOL_W;
  // Comparison width wide enough for both the raw product and the PWM range
  localparam int EXT_W  = ((PROD_W > PWM_W) ? PROD_W : PWM_W) + 1;
  localparam logic [PWM_W-1:0] PWM_MAX = '1;
  localparam logic [PWM_W:0]   STEP    = (PWM_W + 1)'(SLEW_STEP);

  logic [N_NOTES-1:0] ondasMeta;
  logic [N_NOTES-1:0] ondasSync;
  logic [CNT_W-1:0]   noteCount;
  logic [CNT_W-1:0]   activeNotesReg;
  logic [PROD_W-1:0]  prod;
  logic [EXT_W-1:0]   prodExt;
  logic [PWM_W-1:0]   targetNext;
  logic [PWM_W-1:0]   targetReg;
  logic [PWM_W:0]     dutyExt;
  logic [PWM_W:0]     targetExt;
  logic [PWM_W-1:0]   dutyNext;
  logic [PWM_W-1:0]   dutyReg;
  logic [PWM_W-1:0]   pwmCnt;
  logic               pwmOutReg;
  logic               periodStartReg;

  // Count how many synchronised notes are currently high
  always_comb begin
    noteCount = '0;
    for (int i = 0; i < N_NOTES; i++) begin
      noteCount = noteCount + CNT_W'(ondasSync[i]);
    end
  end

  // Amplitude target: notes x volume, clipped to full scale instead of wrapping
  always_comb begin
    prod       = PROD_W'(noteCount) * PROD_W'(bus.volumen);
    prodExt    = EXT_W'(prod);
    targetNext = (prodExt > EXT_W'(PWM_MAX)) ? PWM_MAX : prodExt[PWM_W-1:0];
  end

  // Next duty: move toward the target by at most one step, never overshooting it
  always_comb begin
    dutyExt   = {1'b0, dutyReg};
    targetExt = {1'b0, targetReg};
    dutyNext  = dutyReg;
    if (SLEW_STEP == 0) begin
      dutyNext = targetReg;
    end else if (targetExt > dutyExt) begin
      dutyNext = (targetExt - dutyExt > STEP) ? PWM_W'(dutyExt + STEP) : targetReg;
    end else if (targetExt < dutyExt) begin
      dutyNext = (dutyExt - targetExt > STEP) ? PWM_W'(dutyExt - STEP) : targetReg;
    end
  end

  // Synchroniser, mixer registers, PWM counter and output comparator
  always_ff @(posedge clockIn) begin
    if (reset) begin
      ondasMeta      <= '0;
      ondasSync      <= '0;
      activeNotesReg <= '0;
      targetReg      <= '0;
      dutyReg        <= '0;
      pwmCnt         <= '0;
      pwmOutReg      <= 1'b0;
      periodStartReg <= 1'b0;
    end else begin
      ondasMeta      <= bus.ondas;
      ondasSync      <= ondasMeta;
      activeNotesReg <= noteCount;
      targetReg      <= targetNext;
      pwmCnt         <= pwmCnt + PWM_W'(1);
      periodStartReg <= (pwmCnt == '0);
      pwmOutReg      <= (pwmCnt < dutyReg);
      // Duty is only replaced on the last cycle so each period is whole
      if (pwmCnt == PWM_MAX) begin
        dutyReg <= dutyNext;
      end
    end
  end

  assign bus.activeNotes = activeNotesReg;
  assign bus.duty        = dutyReg;
  assign bus.pwmOut      = pwmOutReg;
  assign bus.periodStart = periodStartReg;
endmodule

// File: tb/tb_note_mixer_pwm.sv
// Bench for note_mixer_pwm: three configurations driven by one shared stimulus stream.
// Expected outputs come from a timeline model indexed by clock edges since reset release.
// No backpressure involved; every output is compared on every falling edge.
module tb_note_mixer_pwm;
  logic        clk;
  logic        rstDrv;
  logic [11:0] ondasDrv;
  logic [6:0]  volDrv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  note_mixer_pwm_if #(.N_NOTES(12), .VOL_W(7), .PWM_W(11)) busA ();
  note_mixer_pwm_if #(.N_NOTES(12), .VOL_W(7), .PWM_W(11)) busB ();
  note_mixer_pwm_if #(.N_NOTES(12), .VOL_W(7), .PWM_W(8))  busC ();

  assign busA.ondas   = ondasDrv;
  assign busA.volumen = volDrv;
  assign busB.ondas   = ondasDrv;
  assign busB.volumen = volDrv;
  assign busC.ondas   = ondasDrv;
  assign busC.volumen = volDrv;

  note_mixer_pwm #(.N_NOTES(12), .VOL_W(7), .PWM_W(11), .SLEW_STEP(256)) dutA (
    .clockIn(clk), .reset(rstDrv), .bus(busA));
  note_mixer_pwm #(.N_NOTES(12), .VOL_W(7), .PWM_W(11), .SLEW_STEP(0)) dutB (
    .clockIn(clk), .reset(rstDrv), .bus(busB));
  note_mixer_pwm #(.N_NOTES(12), .VOL_W(7), .PWM_W(8), .SLEW_STEP(0)) dutC (
    .clockIn(clk), .reset(rstDrv), .bus(busC));

  int total;
  int bad;
  int edgeNo;
  int pcQ[$];
  int volQ[$];
  int dutyM[3];
  int hiCnt[3];
  int psCnt[3];
  int pwmBits[3] = '{11, 11, 8};
  int slewOf[3]  = '{256, 0, 0};
  int upA[8]     = '{256, 512, 768, 1024, 1280, 1524, 1524, 1524};
  int downA[7]   = '{1268, 1012, 756, 500, 244, 0, 0};

  task automatic checkVal(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at edge %0d", tag, got, exp, edgeNo);
    end
  endtask

  function automatic int popc(input logic [11:0] v);
    int c = 0;
    for (int i = 0; i < 12; i++) c += int'(v[i]);
    return c;
  endfunction

  // Popcount / volume applied at edge k (k counted from 1 after reset); nothing before reset release
  function automatic int histPc(input int k);
    return (k < 1) ? 0 : pcQ[k-1];
  endfunction

  function automatic int histVol(input int k);
    return (k < 1) ? 0 : volQ[k-1];
  endfunction

  function automatic int satTo(input int p, input int mx);
    return (p > mx) ? mx : p;
  endfunction

  function automatic int slewTo(input int d, input int t, input int s);
    if (s == 0) return t;
    if (t > d) return (d + s < t) ? d + s : t;
    if (t < d) return (d - s > t) ? d - s : t;
    return d;
  endfunction

  // One clock: capture what the DUTs will sample, advance the model, compare on the falling edge
  task automatic step();
    logic r;
    int pc, vo, n, dBefore;
    int expAn, expDuty, expPwm, expPs;
    int obsAn[3], obsDuty[3], obsPwm[3], obsPs[3];
    r  = rstDrv;
    pc = popc(ondasDrv);
    vo = int'(volDrv);
    @(posedge clk);
    if (r) begin
      edgeNo = 0;
      pcQ.delete();
      volQ.delete();
    end else begin
      edgeNo++;
      pcQ.push_back(pc);
      volQ.push_back(vo);
    end
    @(negedge clk);
    obsAn   = '{int'(busA.activeNotes), int'(busB.activeNotes), int'(busC.activeNotes)};
    obsDuty = '{int'(busA.duty), int'(busB.duty), int'(busC.duty)};
    obsPwm  = '{int'(busA.pwmOut), int'(busB.pwmOut), int'(busC.pwmOut)};
    obsPs   = '{int'(busA.periodStart), int'(busB.periodStart), int'(busC.periodStart)};
    for (int i = 0; i < 3; i++) begin
      n = 1 << pwmBits[i];
      dBefore = 0;
      if (r) begin
        dutyM[i] = 0;
        hiCnt[i] = 0;
        expAn = 0; expDuty = 0; expPwm = 0; expPs = 0;
      end else begin
        dBefore = dutyM[i];
        if (edgeNo % n == 0)
          dutyM[i] = slewTo(dutyM[i], satTo(histPc(edgeNo-3) * histVol(edgeNo-1), n-1), slewOf[i]);
        expAn   = histPc(edgeNo-2);
        expDuty = dutyM[i];
        expPwm  = (((edgeNo-1) % n) < dBefore) ? 1 : 0;
        expPs   = (((edgeNo-1) % n) == 0) ? 1 : 0;
      end
      checkVal($sformatf("activeNotes[%0d]", i), obsAn[i], expAn);
      checkVal($sformatf("duty[%0d]", i), obsDuty[i], expDuty);
      checkVal($sformatf("pwmOut[%0d]", i), obsPwm[i], expPwm);
      checkVal($sformatf("periodStart[%0d]", i), obsPs[i], expPs);
      psCnt[i] += obsPs[i];
      if (!r) begin
        hiCnt[i] += obsPwm[i];
        if (edgeNo % n == 0) begin
          checkVal($sformatf("highCount[%0d]", i), hiCnt[i], dBefore);
          hiCnt[i] = 0;
        end
      end
    end
  endtask

  task automatic runCycles(input int k);
    for (int c = 0; c < k; c++) step();
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    edgeNo   = 0;
    dutyM    = '{0, 0, 0};
    hiCnt    = '{0, 0, 0};
    psCnt    = '{0, 0, 0};
    rstDrv   = 1'b1;
    ondasDrv = 12'hFFF;
    volDrv   = 7'd127;

    // Held reset with all notes on at full volume: outputs must stay silent
    runCycles(5);

    // One note, volume 100: synchroniser latency, then duty 100 every period
    rstDrv   = 1'b0;
    ondasDrv = 12'h001;
    volDrv   = 7'd100;
    runCycles(2);
    checkVal("notesBefore3rdEdge", int'(busA.activeNotes), 0);
    step();
    checkVal("notesAt3rdEdge", int'(busA.activeNotes), 1);
    runCycles(2045);
    psCnt = '{0, 0, 0};
    runCycles(2 * 2048);
    checkVal("dutyOneNoteB", int'(busB.duty), 100);
    checkVal("dutyOneNoteA", int'(busA.duty), 100);
    checkVal("dutyOneNoteC", int'(busC.duty), 100);
    checkVal("periodPulsesB", psCnt[1], 2);
    checkVal("periodPulsesC", psCnt[2], 16);

    // Full chord at full volume from a fresh reset: ramp up, then ramp down on silence
    rstDrv = 1'b1;
    step();
    rstDrv   = 1'b0;
    ondasDrv = 12'hFFF;
    volDrv   = 7'd127;
    for (int k = 0; k < 8; k++) begin
      runCycles(2048);
      checkVal($sformatf("rampUp%0d", k), int'(busA.duty), upA[k]);
      checkVal("fullChordB", int'(busB.duty), 1524);
      checkVal("saturatedC", int'(busC.duty), 255);
    end
    volDrv = 7'd0;
    for (int k = 0; k < 7; k++) begin
      runCycles(2048);
      checkVal($sformatf("rampDown%0d", k), int'(busA.duty), downA[k]);
      checkVal("silentB", int'(busB.duty), 0);
    end

    // Random chords and volumes held for random spans
    for (int s = 0; s < 30; s++) begin
      ondasDrv = 12'($urandom);
      volDrv   = 7'($urandom_range(0, 127));
      runCycles($urandom_range(40, 700));
    end

    // Steady duty 1000, then a one-cycle reset in the middle of a period
    rstDrv = 1'b1;
    step();
    rstDrv   = 1'b0;
    ondasDrv = 12'h0FF;
    volDrv   = 7'd125;
    runCycles(2 * 2048 + 500);
    checkVal("steadyB", int'(busB.duty), 1000);
    checkVal("midPeriodHighB", int'(busB.pwmOut), 1);
    rstDrv = 1'b1;
    step();
    checkVal("resetPwmB", int'(busB.pwmOut), 0);
    checkVal("resetDutyB", int'(busB.duty), 0);
    rstDrv = 1'b0;
    runCycles(2048);
    checkVal("restartRampA", int'(busA.duty), 256);
    checkVal("restartB", int'(busB.duty), 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
